// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared select encodings and triangle direction type for sig_gen
package sig_gen_pkg;

   localparam logic [1:0] SEL_SQUARE = 2'd0;
   localparam logic [1:0] SEL_SAW    = 2'd1;
   localparam logic [1:0] SEL_TRI    = 2'd2;
   localparam logic [1:0] SEL_HOLD   = 2'd3;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/sig_gen_sq_cnt.sv
// sig_gen_sq_cnt: square-wave half-period counter with rise/fall strobes
module sig_gen_sq_cnt
   import sig_gen_pkg::*;
#(
   parameter int SQ_HALF = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_sel,
   output logic       o_rise,
   output logic       o_fall
);

   localparam int CW = $clog2(2 * SQ_HALF);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   // count only in square mode, freeze in hold, otherwise park at 0 so re-entry starts a fresh half period
   always_comb
      w_cnt_nxt = (i_sel == SEL_HOLD)              ? r_cnt :
                  (i_sel != SEL_SQUARE)            ? '0    :
                  (r_cnt == CW'(2 * SQ_HALF - 1))  ? '0    : r_cnt + 1'b1;

   // counter register, cleared asynchronously
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) r_cnt <= '0;
      else       r_cnt <= w_cnt_nxt;

   assign o_rise = (i_sel == SEL_SQUARE) && (r_cnt == CW'(SQ_HALF - 1));
   assign o_fall = (i_sel == SEL_SQUARE) && (r_cnt == CW'(2 * SQ_HALF - 1));

endmodule

// File: rtl/sig_gen.sv
// sig_gen: periodic square/sawtooth/triangle sample generator bounded to 0..AMP
module sig_gen
   import sig_gen_pkg::*;
#(
   parameter int WIDTH   = 5,
   parameter int AMP     = 20,
   parameter int SQ_HALF = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       wave_choise,
   output logic [WIDTH-1:0] wave
);

   localparam logic [WIDTH-1:0] AMP_W = WIDTH'(AMP);

   logic [WIDTH-1:0] r_wave;
   logic [WIDTH-1:0] w_wave_nxt;
   dir_t             r_dir;
   dir_t             w_dir_nxt;
   logic             w_rise;
   logic             w_fall;

   sig_gen_sq_cnt #(.SQ_HALF(SQ_HALF)) u_sq_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sel  (wave_choise),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // next sample and direction; non-triangle modes re-derive dir from the level so triangle entry stays in range
   always_comb begin
      w_wave_nxt = r_wave;
      w_dir_nxt  = r_dir;
      case (wave_choise)
         SEL_SQUARE: begin
            w_wave_nxt = w_rise ? AMP_W : w_fall ? '0 : r_wave;
            w_dir_nxt  = (r_wave == AMP_W) ? DOWN : UP;
         end
         SEL_SAW: begin
            w_wave_nxt = (r_wave >= AMP_W) ? '0 : r_wave + 1'b1;
            w_dir_nxt  = (r_wave == AMP_W) ? DOWN : UP;
         end
         SEL_TRI: begin
            if (r_dir == UP) begin
               w_wave_nxt = (r_wave >= AMP_W) ? AMP_W - 1'b1 : r_wave + 1'b1;
               w_dir_nxt  = (r_wave >= AMP_W - 1'b1) ? DOWN : UP;
            end else begin
               w_wave_nxt = (r_wave == '0) ? WIDTH'(1) : r_wave - 1'b1;
               w_dir_nxt  = (r_wave <= WIDTH'(1)) ? UP : DOWN;
            end
         end
         default: begin
            w_wave_nxt = r_wave;
            w_dir_nxt  = r_dir;
         end
      endcase
   end

   // sample and direction registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         r_wave <= '0;
         r_dir  <= UP;
      end else begin
         r_wave <= w_wave_nxt;
         r_dir  <= w_dir_nxt;
      end

   assign wave = r_wave;

endmodule

// File: tb/tb_sig_gen.sv
// tb_sig_gen: directed self-checking bench for sig_gen
module tb_sig_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] wave_choise = 2'd0;
   logic [4:0] wave;
   int         n_run = 0;
   int         n_fail = 0;

   sig_gen #(.WIDTH(5), .AMP(20), .SQ_HALF(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wave_choise (wave_choise),
      .wave        (wave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [4:0] exp_v);
      n_run++;
      assert (wave === exp_v) else begin
         n_fail++;
         $error("FAIL %s: wave=%0d expected %0d", tag, wave, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst_n = 1'b1;
      step();
      chk("reset", 5'd0);
      rst_n = 1'b0;
   endtask

   initial begin
      // reset state held across an edge
      wave_choise = 2'd0;
      step();
      rst_pulse();

      // square: edges 10..19 and 30..39 high
      for (int k = 1; k <= 40; k++) begin
         step();
         chk($sformatf("square e%0d", k), ((k % 20) >= 10) ? 5'd20 : 5'd0);
      end

      // sawtooth 1..20 then wrap
      wave_choise = 2'd1;
      rst_pulse();
      for (int k = 1; k <= 25; k++) begin
         step();
         chk($sformatf("saw e%0d", k), (k <= 20) ? 5'(k) : 5'(k - 21));
      end

      // triangle 1..20, 19..0, 1..5
      wave_choise = 2'd2;
      rst_pulse();
      for (int k = 1; k <= 45; k++) begin
         step();
         chk($sformatf("tri e%0d", k), (k <= 20) ? 5'(k) : (k <= 40) ? 5'(40 - k) : 5'(k - 40));
      end

      // saw at 20 -> triangle turns down
      wave_choise = 2'd1;
      rst_pulse();
      repeat (20) step();
      chk("saw to 20", 5'd20);
      wave_choise = 2'd2;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("saw20->tri e%0d", k), 5'(20 - k));
      end

      // saw at 7 -> triangle keeps rising
      wave_choise = 2'd1;
      rst_pulse();
      repeat (7) step();
      chk("saw to 7", 5'd7);
      wave_choise = 2'd2;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("saw7->tri e%0d", k), 5'(7 + k));
      end

      // triangle at 13 -> square, with a hold in the middle that freezes the counter
      wave_choise = 2'd2;
      rst_pulse();
      repeat (13) step();
      chk("tri to 13", 5'd13);
      wave_choise = 2'd0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("tri13->sq e%0d", k), 5'd13);
      end
      wave_choise = 2'd3;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("hold e%0d", k), 5'd13);
      end
      wave_choise = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("sq resume e%0d", k), 5'd13);
      end
      step();
      chk("sq rise", 5'd20);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("sq high e%0d", k), 5'd20);
      end
      step();
      chk("sq fall", 5'd0);

      // hold in sawtooth then resume
      wave_choise = 2'd1;
      rst_pulse();
      repeat (5) step();
      wave_choise = 2'd3;
      repeat (4) step();
      chk("saw hold", 5'd5);
      wave_choise = 2'd1;
      step();
      chk("saw resume", 5'd6);

      // asynchronous reset mid-triangle
      wave_choise = 2'd2;
      rst_pulse();
      repeat (15) step();
      chk("tri to 15", 5'd15);
      #3 rst_n = 1'b1;
      #1 chk("async reset", 5'd0);
      #2 rst_n = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("tri restart e%0d", k), 5'(k));
      end

      // asynchronous reset then square restart
      #3 rst_n = 1'b1;
      #1 chk("async reset 2", 5'd0);
      wave_choise = 2'd0;
      #2 rst_n = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("sq restart e%0d", k), (k >= 10) ? 5'd20 : 5'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
